// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes strobed in on din/din_rdy are queued in
// a small FIFO and shifted out LSB first on tx, frames back to back while data remains.
module uart_tx_buf #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_rdy,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       tx
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_TICK  = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic last_tick;
    logic pop;
    logic push;

    assign last_tick = (baud_cnt == LAST_TICK);
    assign pop       = !empty && ((state == IDLE) || ((state == STOP) && last_tick));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = din_rdy && (!full || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            full     <= (count_next == FULL_COUNT);
            empty    <= (count_next == '0);
            overflow <= din_rdy && full && !pop;
        end
    end

    // tx and busy are registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx   <= 1'b0;
                    busy <= 1'b1;
                    if (last_tick) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx   <= shift[0];
                    busy <= 1'b1;
                    if (last_tick) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx   <= 1'b1;
                    busy <= 1'b1;
                    if (last_tick) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
